// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANTED} uart_arb_state_t;

  localparam int unsigned TIMEOUT_COUNT_W = 16;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority pick: first asserted request at or above ptr, wrapping modulo N.
module rr_priority_select #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  int unsigned cand;

  // Scan N candidates starting at ptr; explicit wrap keeps non-power-of-two N correct.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte stream, with a stall watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_SOURCES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 86800,
  parameter int unsigned TIMEOUT_W      = 17
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [8*NUM_SOURCES-1:0]       s_tdata,
  input  logic [NUM_SOURCES-1:0]         s_tvalid,
  input  logic [NUM_SOURCES-1:0]         s_tlast,
  output logic [NUM_SOURCES-1:0]         s_tready,
  output logic [7:0]                     m_tdata,
  output logic                           m_tvalid,
  output logic                           m_tlast,
  input  logic                           m_tready,
  output logic [$clog2(NUM_SOURCES)-1:0] grant_id,
  output logic                           busy,
  output logic [TIMEOUT_COUNT_W-1:0]     timeout_count
);

  localparam int unsigned IdxW = $clog2(NUM_SOURCES);

  uart_arb_state_t             state_q, state_d;
  logic [IdxW-1:0]             grant_q, grant_d;
  logic [IdxW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [TIMEOUT_W-1:0]        wdog_q, wdog_d;
  logic [TIMEOUT_COUNT_W-1:0]  tcount_q, tcount_d;
  logic                        sel_found;
  logic [IdxW-1:0]             sel_idx;
  logic [IdxW-1:0]             next_ptr;
  logic                        src_valid;
  logic                        xfer;
  logic                        wdog_expire;

  rr_priority_select #(
    .N    (NUM_SOURCES),
    .IdxW (IdxW)
  ) u_select (
    .req   (s_tvalid),
    .ptr   (rr_ptr_q),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Pass the owner's stream through while granted; everything is quiet in IDLE.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    busy     = 1'b0;
    if (state_q == ARB_GRANTED) begin
      busy              = 1'b1;
      m_tdata           = s_tdata[8*grant_q +: 8];
      m_tvalid          = s_tvalid[grant_q];
      m_tlast           = s_tlast[grant_q];
      s_tready[grant_q] = m_tready;
    end
  end

  assign grant_id      = grant_q;
  assign timeout_count = tcount_q;

  // Grant/release decisions; watchdog only ticks on source starvation, never on sink backpressure.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    tcount_d    = tcount_q;
    src_valid   = s_tvalid[grant_q];
    xfer        = m_tvalid & m_tready;
    next_ptr    = (grant_q == IdxW'(NUM_SOURCES - 1)) ? '0 : grant_q + 1'b1;
    wdog_expire = (state_q == ARB_GRANTED) && !src_valid &&
                  (wdog_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    case (state_q)
      ARB_IDLE: begin
        wdog_d = '0;
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = ARB_GRANTED;
        end
      end
      ARB_GRANTED: begin
        if (xfer) begin
          wdog_d = '0;
          if (m_tlast) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (wdog_expire) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
          wdog_d   = '0;
          if (tcount_q != '1) begin
            tcount_d = tcount_q + 1'b1;
          end
        end else if (!src_valid) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; asynchronous reset drops any grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
      tcount_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
      tcount_q <= tcount_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic.
module tb_uart_tx_arbiter;

  localparam int NUM = 4;
  localparam int TMO = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [8*NUM-1:0]   s_tdata;
  logic [NUM-1:0]     s_tvalid;
  logic [NUM-1:0]     s_tlast;
  logic [NUM-1:0]     s_tready;
  logic [7:0]         m_tdata;
  logic               m_tvalid;
  logic               m_tlast;
  logic               m_tready;
  logic [1:0]         grant_id;
  logic               busy;
  logic [15:0]        timeout_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-source packet queues: {last, data}
  logic [8:0] sq [NUM][$];
  bit         vtr[$];
  bit         btr[$];
  logic [1:0] gtr[$];
  int         xcnt[NUM];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_SOURCES    (NUM),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_W      (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tlast       (m_tlast),
    .m_tready      (m_tready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  task automatic set_src(input int i, input logic v, input logic [7:0] d, input logic l);
    s_tvalid[i]       = v;
    s_tdata[8*i +: 8] = d;
    s_tlast[i]        = l;
  endtask

  task automatic clear_inputs();
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  // Drive queued packets; expected output is plain round-robin over non-empty sources.
  task automatic run_stream(input int ready_pct, input int gap_pct, input int max_cycles);
    logic [8:0]  cp [NUM][$];
    logic [10:0] exp_q[$];
    logic [10:0] e;
    logic [8:0]  b;
    logic [NUM-1:0] one_hot;
    bit          started[NUM];
    bit          held[NUM];
    int          gap[NUM];
    int          ptr, s, found, cyc, g;
    logic        v;
    for (int i = 0; i < NUM; i++) begin
      cp[i]      = sq[i];
      started[i] = 1'b1;
      held[i]    = 1'b0;
      gap[i]     = 0;
      xcnt[i]    = 0;
    end
    ptr = 0;
    while (1) begin
      found = -1;
      for (int k = 0; k < NUM; k++) begin
        s = (ptr + k) % NUM;
        if (cp[s].size() > 0) begin
          found = s;
          break;
        end
      end
      if (found < 0) break;
      do begin
        b = cp[found].pop_front();
        exp_q.push_back({2'(found), b});
      end while (!b[8]);
      ptr = (found + 1) % NUM;
    end
    vtr.delete();
    btr.delete();
    gtr.delete();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      m_tready = ($urandom_range(99) < ready_pct);
      for (int i = 0; i < NUM; i++) begin
        if (sq[i].size() == 0) begin
          s_tvalid[i] = 1'b0;
        end else begin
          if (held[i] || started[i]) begin
            v = 1'b1;
          end else if (gap[i] < 4 && $urandom_range(99) < gap_pct) begin
            v = 1'b0;
            gap[i]++;
          end else begin
            v = 1'b1;
            gap[i] = 0;
          end
          set_src(i, v, sq[i][0][7:0], sq[i][0][8]);
          held[i] = v;
        end
      end
      @(negedge clk);
      vtr.push_back(m_tvalid);
      btr.push_back(busy);
      gtr.push_back(grant_id);
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        g = int'(grant_id);
        n_checks++;
        if ({grant_id, m_tlast, m_tdata} !== e) begin
          n_fail++;
          $display("FAIL stream_beat: got src %0d last %b data %h, expected src %0d last %b data %h",
                   grant_id, m_tlast, m_tdata, e[10:9], e[8], e[7:0]);
        end
        one_hot    = '0;
        one_hot[g] = 1'b1;
        n_checks++;
        if (s_tready !== one_hot) begin
          n_fail++;
          $display("FAIL stream_tready: got %b expected %b", s_tready, one_hot);
        end
        xcnt[g]++;
        if (sq[g].size() > 0) begin
          started[g] = sq[g][0][8];
          void'(sq[g].pop_front());
        end
        held[g] = 1'b0;
        gap[g]  = 0;
      end
      next_cycle();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_done: %0d beats left after %0d cycles, expected 0", exp_q.size(), cyc);
    end
    for (int i = 0; i < NUM; i++) sq[i].delete();
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    s_tvalid = '1;
    #1;
    n_checks++;
    if ({busy, m_tvalid, s_tready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy %b m_tvalid %b s_tready %b, expected all 0",
               busy, m_tvalid, s_tready);
    end
    n_checks++;
    if (grant_id !== 2'd0 || timeout_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got grant %0d tcount %0d, expected 0 0", grant_id, timeout_count);
    end
    apply_reset();
  endtask

  task automatic test_two_packets();
    apply_reset();
    sq[0] = '{9'h010, 9'h011, 9'h112};
    sq[2] = '{9'h020, 9'h021, 9'h122};
    run_stream(100, 0, 100);
    n_checks++;
    if ({vtr[0], vtr[1], vtr[3], vtr[4], vtr[5]} !== 5'b01101) begin
      n_fail++;
      $display("FAIL two_pkt_valid: got c0..c5 %b%b%b%b%b%b, expected 011101",
               vtr[0], vtr[1], vtr[2], vtr[3], vtr[4], vtr[5]);
    end
    n_checks++;
    if (gtr[1] !== 2'd0 || gtr[5] !== 2'd2) begin
      n_fail++;
      $display("FAIL two_pkt_grant: got %0d then %0d, expected 0 then 2", gtr[1], gtr[5]);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int p = 0; p < 10; p++)
      for (int i = 0; i < NUM; i++) sq[i].push_back({1'b1, 8'(i * 16 + p)});
    run_stream(100, 0, 400);
    for (int i = 0; i < NUM; i++) begin
      n_checks++;
      if (xcnt[i] !== 10) begin
        n_fail++;
        $display("FAIL rr_share[%0d]: got %0d transfers, expected 10", i, xcnt[i]);
      end
    end
    n_checks++;
    if ({gtr[1], gtr[3], gtr[5], gtr[7]} !== 8'b00_01_10_11) begin
      n_fail++;
      $display("FAIL rr_order: got %0d %0d %0d %0d, expected 0 1 2 3",
               gtr[1], gtr[3], gtr[5], gtr[7]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    set_src(1, 1'b1, 8'h31, 1'b0);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (!(busy === 1'b1 && grant_id === 2'd1 && m_tdata === 8'h31)) begin
      n_fail++;
      $display("FAIL bp_first: got busy %b grant %0d data %h, expected 1 1 31",
               busy, grant_id, m_tdata);
    end
    next_cycle();
    set_src(1, 1'b1, 8'h32, 1'b1);
    set_src(0, 1'b1, 8'h05, 1'b1);
    m_tready = 1'b0;
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (!(busy === 1'b1 && grant_id === 2'd1 && timeout_count === 16'd0 && s_tready === 4'b0))
        ok = 1'b0;
      next_cycle();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_hold: got busy %b grant %0d tcount %0d, expected 1 1 0 throughout",
               busy, grant_id, timeout_count);
    end
    m_tready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!(m_tdata === 8'h32 && m_tlast === 1'b1 && s_tready === 4'b0010)) begin
      n_fail++;
      $display("FAIL bp_last: got data %h last %b tready %b, expected 32 1 0010",
               m_tdata, m_tlast, s_tready);
    end
    next_cycle();
    set_src(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: got busy %b expected 0", busy);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (!(busy === 1'b1 && grant_id === 2'd0 && m_tdata === 8'h05)) begin
      n_fail++;
      $display("FAIL bp_next: got busy %b grant %0d data %h, expected 1 0 05",
               busy, grant_id, m_tdata);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    set_src(3, 1'b1, 8'hA3, 1'b0);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (!(grant_id === 2'd3 && m_tvalid === 1'b1)) begin
      n_fail++;
      $display("FAIL to_grant: got grant %0d valid %b, expected 3 1", grant_id, m_tvalid);
    end
    next_cycle();
    set_src(3, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h07, 1'b1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      next_cycle();
    end
    n_checks++;
    if (n !== TMO) begin
      n_fail++;
      $display("FAIL to_cycles: got busy for %0d cycles, expected %0d", n, TMO);
    end
    n_checks++;
    if (timeout_count !== 16'd1) begin
      n_fail++;
      $display("FAIL to_count: got %0d expected 1", timeout_count);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (!(busy === 1'b1 && grant_id === 2'd0 && m_tdata === 8'h07)) begin
      n_fail++;
      $display("FAIL to_next: got busy %b grant %0d data %h, expected 1 0 07",
               busy, grant_id, m_tdata);
    end
    next_cycle();
    clear_inputs();
  endtask

  // Runs right after test_timeout so the cleared counter and pointer are observable.
  task automatic test_reset_mid_packet();
    next_cycle();
    set_src(2, 1'b1, 8'hC0, 1'b0);
    next_cycle();
    next_cycle();
    set_src(2, 1'b1, 8'hC1, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({m_tvalid, s_tready, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got valid %b tready %b busy %b, expected all 0",
               m_tvalid, s_tready, busy);
    end
    set_src(2, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'hD0, 1'b1);
    set_src(3, 1'b1, 8'hD3, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if (!(busy === 1'b0 && grant_id === 2'd0 && timeout_count === 16'd0)) begin
      n_fail++;
      $display("FAIL rst_mid_regs: got busy %b grant %0d tcount %0d, expected 0 0 0",
               busy, grant_id, timeout_count);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (!(busy === 1'b1 && grant_id === 2'd0)) begin
      n_fail++;
      $display("FAIL rst_mid_restart: got busy %b grant %0d, expected 1 0", busy, grant_id);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_single_beat();
    apply_reset();
    sq[0] = '{9'h1AA};
    sq[1] = '{9'h0B0, 9'h1B1};
    run_stream(100, 0, 50);
    n_checks++;
    if ({btr[1], btr[2], btr[3]} !== 3'b101 || gtr[1] !== 2'd0 || gtr[3] !== 2'd1) begin
      n_fail++;
      $display("FAIL single_beat: got busy %b%b%b grants %0d %0d, expected 101 grants 0 1",
               btr[1], btr[2], btr[3], gtr[1], gtr[3]);
    end
  endtask

  task automatic test_random();
    int npk, len;
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      for (int i = 0; i < NUM; i++) begin
        npk = $urandom_range(4, 1);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(5, 1);
          for (int j = 0; j < len; j++) sq[i].push_back({(j == len - 1), 8'($urandom)});
        end
      end
      run_stream(70, 35, 5000);
      n_checks++;
      if (timeout_count !== 16'd0) begin
        n_fail++;
        $display("FAIL random_tcount: got %0d expected 0", timeout_count);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_two_packets();
    test_round_robin();
    test_single_beat();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
